// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU, with divide-by-zero and overflow flagged.
// Latency: response valid XLEN+1 edges after acceptance (normal), 1 edge after acceptance (zero/overflow).
// Backpressure: response held stable until out_ready; no new request accepted until the cycle after the handshake.
module iter_divider #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            div_by_zero,
  output logic            overflow
);

  // SETUP classifies the latched operands and prepares magnitudes, giving
  // the special cases their one-edge latency and the normal path XLEN+1.
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_CALC, S_DONE} state_t;

  state_t state_q, state_d;

  logic [1:0]      op_q;
  logic [XLEN-1:0] dvd_q, dvs_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] mag_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] result_q;
  logic            dbz_q, ovf_q;

  // Operand classification on the latched request.
  logic            is_signed, is_rem, dvd_neg, dvs_neg, dvs_zero, ovf_case;
  logic [XLEN-1:0] dvd_abs, dvs_abs, min_val;

  assign is_signed = ~op_q[0];
  assign is_rem    = op_q[1];
  assign dvd_neg   = is_signed & dvd_q[XLEN-1];
  assign dvs_neg   = is_signed & dvs_q[XLEN-1];
  assign dvd_abs   = dvd_neg ? -dvd_q : dvd_q;
  assign dvs_abs   = dvs_neg ? -dvs_q : dvs_q;
  assign min_val   = {1'b1, {(XLEN-1){1'b0}}};
  assign dvs_zero  = (dvs_q == '0);
  assign ovf_case  = is_signed && (dvd_q == min_val) && (dvs_q == '1);

  // One restoring step: shift the next dividend bit into the partial
  // remainder, keep the trial difference when it did not go negative.
  logic [XLEN:0]   shifted, trial, rem_step;
  logic [XLEN-1:0] quo_step, rem_mag, quo_fix, rem_fix;
  logic            take;

  assign shifted  = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
  assign trial    = shifted - {1'b0, mag_q};
  assign take     = ~trial[XLEN];
  assign rem_step = take ? trial : shifted;
  assign quo_step = {quo_q[XLEN-2:0], take};
  assign rem_mag  = rem_step[XLEN-1:0];
  assign quo_fix  = (dvd_neg ^ dvs_neg) ? -quo_step : quo_step;
  assign rem_fix  = dvd_neg ? -rem_mag : rem_mag;

  // The remainder never reaches the divisor, so its top bit is always clear
  // between steps; it only exists to hold the trial-subtract width.
  logic rem_top_unused;
  assign rem_top_unused = rem_q[XLEN];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs, decoded from state alone.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !kill) state_d = S_SETUP;
      end
      S_SETUP: begin
        if (kill)                      state_d = S_IDLE;
        else if (dvs_zero || ovf_case) state_d = S_DONE;
        else                           state_d = S_CALC;
      end
      S_CALC: begin
        if (kill)               state_d = S_IDLE;
        else if (cnt_q == '0)   state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (kill || out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: latch request, prepare magnitudes or special result, iterate, fix up signs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q     <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      mag_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && !kill) begin
            op_q  <= op;
            dvd_q <= dividend;
            dvs_q <= divisor;
          end
        end
        S_SETUP: begin
          if (!kill) begin
            if (dvs_zero) begin
              result_q <= is_rem ? dvd_q : '1;
              dbz_q    <= 1'b1;
              ovf_q    <= 1'b0;
            end else if (ovf_case) begin
              result_q <= is_rem ? '0 : min_val;
              dbz_q    <= 1'b0;
              ovf_q    <= 1'b1;
            end else begin
              quo_q <= dvd_abs;
              rem_q <= '0;
              mag_q <= dvs_abs;
              cnt_q <= CNT_W'(XLEN - 1);
              dbz_q <= 1'b0;
              ovf_q <= 1'b0;
            end
          end
        end
        S_CALC: begin
          if (!kill) begin
            quo_q <= quo_step;
            rem_q <= rem_step;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == '0) result_q <= is_rem ? rem_fix : quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign result      = result_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: scoreboard of expected responses.
// Inputs driven 1ns after the rising edge; outputs sampled at the same point.
// Every wait on the DUT is bounded by a cycle budget.
module tb_iter_divider;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            kill;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            div_by_zero;
  logic            overflow;

  always #5 clk = ~clk;

  iter_divider #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .dividend    (dividend),
    .divisor     (divisor),
    .kill        (kill),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  typedef struct {
    logic [31:0] res;
    logic        dbz;
    logic        ovf;
    int          lat;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        d;
    logic        v;
    int          lat;
  } vec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model of RV32M divide semantics.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic d, output logic v);
    logic signed [31:0] sa, sb_v;
    sa = a; sb_v = b;
    d = 1'b0; v = 1'b0;
    if (b == 32'd0) begin
      d = 1'b1;
      r = o[1] ? a : 32'hFFFF_FFFF;
    end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      v = 1'b1;
      r = o[1] ? 32'd0 : 32'h8000_0000;
    end else if (!o[0]) begin
      r = o[1] ? 32'(sa % sb_v) : 32'(sa / sb_v);
    end else begin
      r = o[1] ? a % b : a / b;
    end
  endfunction

  // Drive one request (waiting for in_ready) and record its expected response.
  task automatic send(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic ed, input logic ev, input int el);
    int w;
    w = 0;
    while (in_ready !== 1'b1 && w < 100) begin
      @(posedge clk); #1; w++;
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL send_ready: in_ready=%b want 1", in_ready);
    end
    in_valid = 1'b1; op = o; dividend = a; divisor = b;
    sb.push_back('{res: er, dbz: ed, ovf: ev, lat: el});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges after acceptance until out_valid is seen (bounded).
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (out_valid !== 1'b1 && lat < 100);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (in_ready !== 1'b1)   begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (result !== 32'd0)    begin n_bad++; $display("FAIL reset_result: got %h want 0", result); end
    n_vec++; if ({div_by_zero, overflow} !== 2'b00) begin
      n_bad++; $display("FAIL reset_flags: got dbz=%b ovf=%b want 0 0", div_by_zero, overflow);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    vec_t v[11];
    exp_t e;
    int   lat;
    v[0]  = '{2'b00, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 1'b0, 33};
    v[1]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0, 33};
    v[2]  = '{2'b01, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 1'b0, 1'b0, 33};
    v[3]  = '{2'b11, 32'hFFFF_FFFF, 32'd2,         32'd1,         1'b0, 1'b0, 33};
    v[4]  = '{2'b00, 32'd100,       32'd7,         32'd14,        1'b0, 1'b0, 33};
    v[5]  = '{2'b10, 32'd100,       32'd7,         32'd2,         1'b0, 1'b0, 33};
    v[6]  = '{2'b00, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, 1'b0, 1};
    v[7]  = '{2'b11, 32'd5,         32'd0,         32'd5,         1'b1, 1'b0, 1};
    v[8]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1};
    v[9]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, 1'b1, 1};
    v[10] = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, 1'b0, 33};
    for (int i = 0; i < 11; i++) begin
      send(v[i].op, v[i].a, v[i].b, v[i].r, v[i].d, v[i].v, v[i].lat);
      wait_out(lat);
      if (sb.size() == 0) begin
        n_vec++; n_bad++; $display("FAIL vec%0d_scoreboard: queue empty", i);
      end else begin
        e = sb.pop_front();
        n_vec++; if (lat != e.lat) begin
          n_bad++; $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, e.lat);
        end
        n_vec++; if (result !== e.res) begin
          n_bad++; $display("FAIL vec%0d_result: got %h want %h", i, result, e.res);
        end
        n_vec++; if ({div_by_zero, overflow} !== {e.dbz, e.ovf}) begin
          n_bad++; $display("FAIL vec%0d_flags: got dbz=%b ovf=%b want %b %b", i, div_by_zero, overflow, e.dbz, e.ovf);
        end
      end
      consume();
    end
  endtask

  task automatic test_random();
    exp_t        e;
    int          lat;
    logic [1:0]  o;
    logic [31:0] a, b, r;
    logic        d, ov;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case (i % 4)
        0:       b = $urandom;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = -32'($urandom_range(1, 15));
        default: b = (i % 8 == 3) ? 32'd0 : 32'($urandom_range(1, 1000));
      endcase
      if (i == 5) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      model(o, a, b, r, d, ov);
      send(o, a, b, r, d, ov, (d | ov) ? 1 : 33);
      wait_out(lat);
      if (sb.size() == 0) begin
        n_vec++; n_bad++; $display("FAIL rnd%0d_scoreboard: queue empty", i);
      end else begin
        e = sb.pop_front();
        n_vec++; if (lat != e.lat) begin
          n_bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, e.lat);
        end
        n_vec++; if ({result, div_by_zero, overflow} !== {e.res, e.dbz, e.ovf}) begin
          n_bad++; $display("FAIL rnd%0d_response: op=%0d a=%h b=%h got %h/%b%b want %h/%b%b",
                            i, o, a, b, result, div_by_zero, overflow, e.res, e.dbz, e.ovf);
        end
      end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    send(2'b00, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33);
    wait_out(lat);
    e = sb.pop_front();
    for (int c = 0; c < 5; c++) begin
      n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL hold%0d_valid: got %b want 1", c, out_valid); end
      n_vec++; if (result !== e.res)   begin n_bad++; $display("FAIL hold%0d_result: got %h want %h", c, result, e.res); end
      n_vec++; if ({div_by_zero, overflow} !== 2'b00) begin
        n_bad++; $display("FAIL hold%0d_flags: got %b%b want 00", c, div_by_zero, overflow);
      end
      n_vec++; if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL hold%0d_in_ready: got %b want 0", c, in_ready); end
      @(posedge clk); #1;
    end
    consume();
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL handshake_valid: got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL handshake_in_ready: got %b want 1", in_ready); end
    send(2'b01, 32'd9, 32'd4, 32'd2, 1'b0, 1'b0, 33);
    n_vec++; if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL b2b_accept: in_ready=%b want 0", in_ready); end
    wait_out(lat);
    e = sb.pop_front();
    n_vec++; if (lat != e.lat)       begin n_bad++; $display("FAIL b2b_latency: got %0d want %0d", lat, e.lat); end
    n_vec++; if (result !== e.res)   begin n_bad++; $display("FAIL b2b_result: got %h want %h", result, e.res); end
    consume();
  endtask

  task automatic test_kill();
    exp_t dropped;
    logic seen;
    // Kill mid-calculation: the pending response is abandoned.
    send(2'b00, 32'd1000, 32'd3, 32'd333, 1'b0, 1'b0, 33);
    dropped = sb.pop_back();
    repeat (10) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL kill_calc_valid: got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL kill_calc_idle: in_ready=%b want 1", in_ready); end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0) begin n_bad++; $display("FAIL kill_calc_response: out_valid seen=%b want 0", seen); end
    // Kill in IDLE blocks acceptance.
    in_valid = 1'b1; op = 2'b00; dividend = 32'd50; divisor = 32'd0; kill = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL kill_idle_accept: in_ready=%b want 1", in_ready); end
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0) begin n_bad++; $display("FAIL kill_idle_response: out_valid seen=%b want 0", seen); end
    // Kill beats out_ready on a held response.
    send(2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1);
    dropped = sb.pop_back();
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL kill_done_pre: out_valid=%b want 1", out_valid); end
    kill = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0; out_ready = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL kill_done_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_calc();
    exp_t e;
    int   lat;
    send(2'b00, 32'd12345, 32'd7, 32'd1763, 1'b0, 1'b0, 33);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    n_vec++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
    n_vec++; if (result !== 32'd0)   begin n_bad++; $display("FAIL rstmid_result: got %h want 0", result); end
    n_vec++; if ({div_by_zero, overflow} !== 2'b00) begin
      n_bad++; $display("FAIL rstmid_flags: got %b%b want 00", div_by_zero, overflow);
    end
    send(2'b00, 32'd9, 32'd3, 32'd3, 1'b0, 1'b0, 33);
    wait_out(lat);
    e = sb.pop_front();
    n_vec++; if (lat != e.lat)     begin n_bad++; $display("FAIL rstmid_latency: got %0d want %0d", lat, e.lat); end
    n_vec++; if (result !== e.res) begin n_bad++; $display("FAIL rstmid_result_after: got %h want %h", result, e.res); end
    consume();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
    kill = 1'b0; out_ready = 1'b0;
    test_reset();
    test_vectors();
    test_random();
    test_back_to_back();
    test_kill();
    test_reset_mid_calc();
    n_vec++; if (sb.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain: %0d left want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
